// File: rtl/cpu_pkg.sv
// Shared CPU types: load-type encoding, the zero register index, the MEM/WB register layout.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cpu_pkg;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LB  = 3'd1,
      LBU = 3'd2,
      LH  = 3'd3,
      LHU = 3'd4
   } load_type_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic [4:0]  waddr;
      logic [31:0] alu_result;
      logic [31:0] rdata;
      load_type_e  load_type;
   } memwb_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: picks byte/half/word from a raw memory word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
   import cpu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  load_type_e  load_type,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // select the addressed byte and half-word (half ignores offset[0])
   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   // extend according to load type; unknown codes behave as a full-word load
   always_comb begin
      data = rdata;
      case (load_type)
         LB:      data = {{24{byte_sel[7]}}, byte_sel};
         LBU:     data = {24'd0, byte_sel};
         LH:      data = {{16{half_sel[15]}}, half_sel};
         LHU:     data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register plus result select/alignment; optional retire counter (WB_RETIRE_CNT_EN).
// Latency: one cycle from mem_* inputs to wb_* outputs.
// Backpressure: stall holds the register (write re-presented, idempotent); flush drops the held instruction.
module wb_stage
   import cpu_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_valid,
   input  logic          mem_reg_write,
   input  logic          mem_mem_to_reg,
   input  logic [4:0]    mem_waddr,
   input  logic [DW-1:0] mem_alu_result,
   input  logic [DW-1:0] mem_rdata,
   input  load_type_e    mem_load_type,
   output logic          wb_reg_write,
   output logic [4:0]    wb_waddr,
   output logic [DW-1:0] wb_wd
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]   retire_cnt
`endif
);

   memwb_t      memwb_q;
   logic [31:0] load_data;

   // MEM/WB register: flush wins over stall, stall holds, otherwise capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memwb_q <= '{valid: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, waddr: REG_ZERO,
                      alu_result: '0, rdata: '0, load_type: LW};
      end else if (flush) begin
         memwb_q.valid <= 1'b0;
      end else if (!stall) begin
         memwb_q <= '{valid: mem_valid, reg_write: mem_reg_write, mem_to_reg: mem_mem_to_reg,
                      waddr: mem_waddr, alu_result: mem_alu_result, rdata: mem_rdata,
                      load_type: mem_load_type};
      end
   end

   load_align u_load_align (
      .rdata     (memwb_q.rdata),
      .offset    (memwb_q.alu_result[1:0]),
      .load_type (memwb_q.load_type),
      .data      (load_data)
   );

   // regfile write port; writes to the zero register are suppressed
   always_comb begin
      wb_reg_write = memwb_q.valid & memwb_q.reg_write & (memwb_q.waddr != REG_ZERO);
      wb_waddr     = memwb_q.waddr;
      wb_wd        = memwb_q.mem_to_reg ? load_data : memwb_q.alu_result;
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q;

   // count instructions leaving WB; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt_q <= 32'd0;
      end else if (memwb_q.valid && !stall) begin
         retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a scoreboard of expected regfile writes.
// Latency: expectations are pushed when MEM inputs are driven and popped one edge later.
// Backpressure: stall/flush steps push the held or killed expectation.
module tb_wb_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        mem_valid, mem_reg_write, mem_mem_to_reg;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_alu_result, mem_rdata;
   load_type_e  mem_load_type;
   logic        wb_reg_write;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wd;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   typedef struct {
      logic        rw;
      logic [4:0]  wa;
      logic [31:0] wd;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   wb_stage #(.DW(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_to_reg (mem_mem_to_reg),
      .mem_waddr      (mem_waddr),
      .mem_alu_result (mem_alu_result),
      .mem_rdata      (mem_rdata),
      .mem_load_type  (mem_load_type),
      .wb_reg_write   (wb_reg_write),
      .wb_waddr       (wb_waddr),
      .wb_wd          (wb_wd)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt     (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one MEM-stage instruction and record the write it must produce
   task automatic issue(input logic v, input logic rw, input logic m2r, input logic [4:0] wa,
                        input logic [31:0] alu, input logic [31:0] rd, input load_type_e lt,
                        input logic e_rw, input logic [31:0] e_wd, input string tag);
      exp_t e;
      mem_valid      = v;
      mem_reg_write  = rw;
      mem_mem_to_reg = m2r;
      mem_waddr      = wa;
      mem_alu_result = alu;
      mem_rdata      = rd;
      mem_load_type  = lt;
      e.rw = e_rw; e.wa = wa; e.wd = e_wd; e.tag = tag;
      sb.push_back(e);
   endtask

   // advance one edge and compare the oldest expectation against the WB outputs
   task automatic tick_check();
      exp_t e;
      tick();
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got 0 entries expected >0");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk32({e.tag, "_rw"}, {31'd0, wb_reg_write}, {31'd0, e.rw});
         chk32({e.tag, "_wa"}, {27'd0, wb_waddr}, {27'd0, e.wa});
         chk32({e.tag, "_wd"}, wb_wd, e.wd);
      end
   endtask

   initial begin
      logic [31:0] lb_exp  [4];
      logic [31:0] lbu_exp [4];
      exp_t        held;
      lb_exp  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
      lbu_exp = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_valid = 1'b0; mem_reg_write = 1'b0; mem_mem_to_reg = 1'b0; mem_waddr = 5'd0;
      mem_alu_result = 32'd0; mem_rdata = 32'd0; mem_load_type = LW;
      tick(); tick();
      chk32("rst_rw", {31'd0, wb_reg_write}, 32'd0);
      chk32("rst_wa", {27'd0, wb_waddr}, 32'd0);
      chk32("rst_wd", wb_wd, 32'd0);
`ifdef WB_RETIRE_CNT_EN
      chk32("rst_cnt", retire_cnt, 32'd0);
`endif
      rst_n = 1'b1;

      // ALU result path
      issue(1, 1, 0, 5'd8, 32'h12345678, 32'hDEADBEEF, LW, 1, 32'h12345678, "alu");
      tick_check();

      // byte loads, signed and unsigned, all offsets
      for (int i = 0; i < 4; i++) begin
         issue(1, 1, 1, 5'd3, 32'h1000 + i, 32'h80FF7F01, LB, 1, lb_exp[i], $sformatf("lb%0d", i));
         tick_check();
      end
      for (int i = 0; i < 4; i++) begin
         issue(1, 1, 1, 5'd4, 32'h2000 + i, 32'h80FF7F01, LBU, 1, lbu_exp[i], $sformatf("lbu%0d", i));
         tick_check();
      end

      // half loads, word load, and an undefined type code treated as a word
      issue(1, 1, 1, 5'd5, 32'h3002, 32'h80017FFE, LH, 1, 32'hFFFF8001, "lh2");
      tick_check();
      issue(1, 1, 1, 5'd6, 32'h3000, 32'h80017FFE, LHU, 1, 32'h00007FFE, "lhu0");
      tick_check();
      issue(1, 1, 1, 5'd7, 32'h3003, 32'h80017FFE, LH, 1, 32'hFFFF8001, "lh3");
      tick_check();
      issue(1, 1, 1, 5'd9, 32'h3001, 32'hCAFEF00D, LW, 1, 32'hCAFEF00D, "lw");
      tick_check();
      issue(1, 1, 1, 5'd10, 32'h3001, 32'hA5A55A5A, load_type_e'(3'd7), 1, 32'hA5A55A5A, "lt_undef");
      tick_check();

      // no write to the zero register, no write from a bubble or a non-writing instruction
      issue(1, 1, 0, 5'd0, 32'h55AA55AA, 32'd0, LW, 0, 32'h55AA55AA, "x0");
      tick_check();
      issue(0, 1, 0, 5'd11, 32'h00000077, 32'd0, LW, 0, 32'h00000077, "bubble");
      tick_check();
      issue(1, 0, 0, 5'd12, 32'h00000088, 32'd0, LW, 0, 32'h00000088, "no_rw");
      tick_check();

      // stall held three cycles: the held write repeats while new MEM data is ignored
      issue(1, 1, 0, 5'd13, 32'hB00B1E55, 32'd0, LW, 1, 32'hB00B1E55, "pre_stall");
      tick_check();
      held = '{rw: 1'b1, wa: 5'd13, wd: 32'hB00B1E55, tag: "stall"};
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_waddr = 5'd20 + 5'(i);
         mem_alu_result = 32'h0F0F0000 + i;
         sb.push_back(held);
         tick_check();
      end

      // flush together with stall kills the held write
      flush = 1'b1;
      tick();
      chk32("flush_stall_rw", {31'd0, wb_reg_write}, 32'd0);
      flush = 1'b0; stall = 1'b0;

      // reset mid-stream clears outputs without waiting for an edge
      issue(1, 1, 0, 5'd14, 32'h13572468, 32'd0, LW, 1, 32'h13572468, "pre_rst");
      tick_check();
      rst_n = 1'b0;
      #1;
      chk32("midrst_rw", {31'd0, wb_reg_write}, 32'd0);
      chk32("midrst_wa", {27'd0, wb_waddr}, 32'd0);
      chk32("midrst_wd", wb_wd, 32'd0);
      tick();
      chk32("midrst_hold_rw", {31'd0, wb_reg_write}, 32'd0);
      mem_valid = 1'b0;
      rst_n = 1'b1;
      tick();

`ifdef WB_RETIRE_CNT_EN
      chk32("cnt_after_rst", retire_cnt, 32'd0);
      for (int i = 0; i < 5; i++) begin
         issue(1, 1, 0, 5'd1 + 5'(i), 32'h100 + i, 32'd0, LW, 1, 32'h100 + i, $sformatf("ret%0d", i));
         tick_check();
      end
      issue(0, 0, 0, 5'd0, 32'd0, 32'd0, LW, 0, 32'd0, "ret_drain");
      tick_check();
      chk32("cnt_five", retire_cnt, 32'd5);
      issue(1, 1, 0, 5'd2, 32'h200, 32'd0, LW, 1, 32'h200, "wrap_ld");
      tick_check();
      force dut.retire_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt_q;
      chk32("cnt_preload", retire_cnt, 32'hFFFFFFFF);
      issue(0, 0, 0, 5'd0, 32'd0, 32'd0, LW, 0, 32'd0, "wrap_drain");
      tick_check();
      chk32("cnt_wrap", retire_cnt, 32'd0);
`endif

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
